signed_psum_accumulator: RTL and testbench
==========================================

SIGNED_PSUM_ACCUMULATOR -- requirements
Module: signed_psum_accumulator

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 17: the adder-tree operand width; the incoming partial sum is WIDTH+3 bits signed.
REQ-003 Parameter ACC_W, default 32: the accumulator and result width, which SHALL be at least WIDTH+3.
REQ-004 clk  in  1  the single clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 psum_valid  in  1  psum_data and psum_last are valid this cycle.
REQ-007 psum_ready  out  1  the block accepts a partial sum this cycle.
REQ-008 psum_data  in  WIDTH+3  signed partial sum, equal to the adder-tree S output.
REQ-009 psum_last  in  1  the current partial sum is the last term of a dot product.
REQ-010 res_valid  out  1  res_data, res_terms and res_ovf are valid.
REQ-011 res_ready  in  1  the consumer accepts the result this cycle.
REQ-012 res_data  out  ACC_W  signed accumulated dot product.
REQ-013 res_terms  out  16  number of partial sums in the result.
REQ-014 res_ovf  out  1  the accumulator overflowed during this result.

Function
REQ-015 A partial sum SHALL be accepted exactly when psum_valid and psum_ready are both high.
REQ-016 psum_ready SHALL equal (!res_valid || res_ready), combinationally.
REQ-017 The FSM SHALL have states IDLE (no terms held) and ACCUM (at least one term held); the output register is occupied exactly when res_valid is high.
REQ-018 Accept, non-last: acc <= acc + sign-extended psum_data, term count +1, state -> ACCUM.
REQ-019 Accept, last: res_data <= acc + sign-extended psum_data, res_terms <= count+1, res_valid <= 1, acc <= 0, count <= 0, state -> IDLE.
REQ-020 Latency SHALL be exactly one cycle: the result is visible the cycle after the last term is accepted.
REQ-021 res_valid and the result fields SHALL hold stable until res_ready is sampled high.
REQ-022 Simultaneous drain and new last-accept: the new result SHALL load and res_valid SHALL stay 1, with no bubble.
REQ-023 Drain with no new last-accept SHALL clear res_valid the next cycle.
REQ-024 The term counter SHALL saturate at 65535.
REQ-025 A single-term row (psum_last on the first term) SHALL give res_data equal to sign-extended psum_data and res_terms = 1.
REQ-026 Accumulation in ACCUM SHALL continue while res_valid is held, because only the acceptance rule gates input.

Reset
REQ-027 When rst is sampled high, the block SHALL set acc=0, count=0, state=IDLE, res_valid=0, res_data=0, res_terms=0 and res_ovf=0.
REQ-028 A partially accumulated row SHALL be discarded on reset.
REQ-029 psum_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-030 Macro PSUM_ACC_SAT_EN defined: each addition SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and any clamp within a row SHALL set that row's res_ovf.
REQ-031 Macro undefined: each addition SHALL wrap modulo 2^ACC_W, and res_ovf SHALL be tied 0.

Structure
REQ-032 Package addertree_pkg SHALL hold the PSUM_W(WIDTH) width function, the FSM state enum (IDLE, ACCUM), and the constant TERM_CNT_W=16.
REQ-033 The block SHALL use one sub-module, psum_sat_add, for sign-extension, addition and optional clamping, with an overflow output.

Verification
REQ-034 The bench SHALL cover: terms 5, -3, 10 (last on 10) -> res_data=12, res_terms=3, res_ovf=0, one cycle after the last accept.
REQ-035 The bench SHALL cover: a single term 20'hFFFFF with last -> res_data=-1 (all ones, ACC_W bits), res_terms=1.
REQ-036 The bench SHALL cover: a result held with res_ready=0 for 4 cycles while psum_valid=1 -> psum_ready=0 throughout, res_data stable, and no term lost after the release.
REQ-037 The bench SHALL cover: ACC_W=21 with terms 458745 x3 (last on the 3rd) -> with the macro, res_data=1048575 and res_ovf=1; without it, res_data=-720917.
REQ-038 The bench SHALL cover: terms 100, 200, then rst, then term 7 with last -> res_data=7, res_terms=1.
REQ-039 The bench SHALL cover: res_ready=1 in the same cycle a new last-accept of 4 occurs after prior result 9 -> 9 consumed, 4 appears next cycle, res_valid continuously 1.

Source files
------------

// File: rtl/addertree_pkg.sv
// Shared types and constants for the adder-tree partial-sum accumulator.
package addertree_pkg;

  // Width of the term counter carried alongside each result.
  localparam int unsigned TERM_CNT_W = 16;

  // IDLE: no terms held; ACCUM: at least one term of the current row held.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Partial-sum width produced by the adder tree for a given operand width.
  function automatic int unsigned PSUM_W(input int unsigned width);
    return width + 3;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Sign-extending accumulator adder. Wraps by default; clamps to the signed
// ACC_W range and flags overflow when PSUM_ACC_SAT_EN is defined.
module psum_sat_add #(
  parameter int unsigned PSUM_WIDTH = 20,
  parameter int unsigned ACC_W      = 32
) (
  input  logic [ACC_W-1:0]      acc,
  input  logic [PSUM_WIDTH-1:0] psum,
  output logic [ACC_W-1:0]      sum,
  output logic                  ovf
);

  logic [ACC_W-1:0] psum_ext;

  assign psum_ext = {{(ACC_W - PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};

`ifdef PSUM_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;

  // One guard bit; disagreement with the sign bit means the true sum left the range.
  assign sum_wide = {acc[ACC_W-1], acc} + {psum_ext[ACC_W-1], psum_ext};

  // Clamp toward the side the true sum overflowed to.
  always_comb begin
    sum = sum_wide[ACC_W-1:0];
    ovf = 1'b0;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      ovf = 1'b1;
      sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = acc + psum_ext;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/signed_psum_accumulator.sv
// Accumulates signed adder-tree partial sums into dot-product results with a
// one-entry output register and valid/ready handshakes on both sides.
// Optional macro PSUM_ACC_SAT_EN selects saturating accumulation with res_ovf.
module signed_psum_accumulator
  import addertree_pkg::*;
#(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic [PSUM_W(WIDTH)-1:0] psum_data,
  input  logic                     psum_last,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_W-1:0]         res_data,
  output logic [TERM_CNT_W-1:0]    res_terms,
  output logic                     res_ovf
);

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [TERM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  row_ovf_q, row_ovf_d;
  logic                  res_valid_q, res_valid_d;
  logic [ACC_W-1:0]      res_data_q, res_data_d;
  logic [TERM_CNT_W-1:0] res_terms_q, res_terms_d;
  logic                  res_ovf_q, res_ovf_d;

  logic                  accept;
  logic [ACC_W-1:0]      add_in;
  logic [ACC_W-1:0]      add_sum;
  logic                  add_ovf;
  logic [TERM_CNT_W-1:0] cnt_inc;

  assign psum_ready = !res_valid_q || res_ready;
  assign accept     = psum_valid && psum_ready;

  // A fresh row starts from zero regardless of the accumulator contents.
  assign add_in  = (state_q == IDLE) ? '0 : acc_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TERM_CNT_W'(1);

  psum_sat_add #(
    .PSUM_WIDTH(PSUM_W(WIDTH)),
    .ACC_W     (ACC_W)
  ) u_add (
    .acc (add_in),
    .psum(psum_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Next-state: accumulate, close a row into the output register, drain.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    row_ovf_d   = row_ovf_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_terms_d = res_terms_q;
    res_ovf_d   = res_ovf_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    if (accept) begin
      if (psum_last) begin
        res_valid_d = 1'b1;
        res_data_d  = add_sum;
        res_terms_d = cnt_inc;
        res_ovf_d   = row_ovf_q | add_ovf;
        acc_d       = '0;
        cnt_d       = '0;
        row_ovf_d   = 1'b0;
        state_d     = IDLE;
      end else begin
        acc_d     = add_sum;
        cnt_d     = cnt_inc;
        row_ovf_d = row_ovf_q | add_ovf;
        state_d   = ACCUM;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      row_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_terms_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      row_ovf_q   <= row_ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_terms_q <= res_terms_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_terms = res_terms_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_signed_psum_accumulator.sv
// Bench for signed_psum_accumulator: a 32-bit and a 21-bit accumulator share
// stimulus and are checked against a transaction-level arithmetic model.
module tb_signed_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        psum_valid;
  logic [19:0] psum_data;
  logic        psum_last;
  logic        res_ready;

  logic        rdy_a, rv_a, ro_a;
  logic [31:0] rd_a;
  logic [15:0] rt_a;
  logic        rdy_b, rv_b, ro_b;
  logic [20:0] rd_b;
  logic [15:0] rt_b;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = ACC_W 32, index 1 = ACC_W 21.
  longint m_acc[2];
  longint m_data[2];
  int     m_cnt[2];
  int     m_terms[2];
  bit     m_ovf[2];
  bit     m_rovf[2];
  bit     m_valid[2];
  int     m_w[2] = '{32, 21};

  always #5 clk = ~clk;

  signed_psum_accumulator #(.WIDTH(17), .ACC_W(32)) dut_a (
    .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum_ready(rdy_a),
    .psum_data(psum_data), .psum_last(psum_last), .res_valid(rv_a),
    .res_ready(res_ready), .res_data(rd_a), .res_terms(rt_a), .res_ovf(ro_a)
  );

  signed_psum_accumulator #(.WIDTH(17), .ACC_W(21)) dut_b (
    .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum_ready(rdy_b),
    .psum_data(psum_data), .psum_last(psum_last), .res_valid(rv_b),
    .res_ready(res_ready), .res_data(rd_b), .res_terms(rt_b), .res_ovf(ro_b)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Signed add of one term into a w-bit accumulator, by plain arithmetic.
  function automatic longint madd(input longint a, input longint p, input int w, output bit o);
    longint s, mx, mn;
    s  = a + p;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -mx - 1;
    o  = 1'b0;
`ifdef PSUM_ACC_SAT_EN
    if (s > mx) begin
      s = mx;
      o = 1'b1;
    end else if (s < mn) begin
      s = mn;
      o = 1'b1;
    end
`else
    s = s & ((64'sd1 <<< w) - 1);
    if (s > mx) s = s - (64'sd1 <<< w);
`endif
    return s;
  endfunction

  task automatic cyc(input bit r, input bit pv, input logic [19:0] pd, input bit pl,
                     input bit rr);
    bit     acc_ok, o;
    longint p, s;
    rst = r; psum_valid = pv; psum_data = pd; psum_last = pl; res_ready = rr;
    #1;
    if (!r) begin
      chk("psum_ready_a", rdy_a, (!m_valid[0] || rr));
      chk("psum_ready_b", rdy_b, (!m_valid[1] || rr));
    end
    @(posedge clk);
    acc_ok = pv && (!m_valid[0] || rr);
    p      = longint'($signed(pd));
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_valid[k] = 0;
        m_data[k] = 0; m_terms[k] = 0; m_rovf[k] = 0;
      end else begin
        if (m_valid[k] && rr) m_valid[k] = 0;
        if (acc_ok) begin
          s = madd(m_acc[k], p, m_w[k], o);
          if (pl) begin
            m_data[k]  = s;
            m_terms[k] = (m_cnt[k] + 1 > 65535) ? 65535 : m_cnt[k] + 1;
            m_rovf[k]  = m_ovf[k] | o;
            m_valid[k] = 1;
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
          end else begin
            m_acc[k] = s;
            m_cnt[k] = (m_cnt[k] + 1 > 65535) ? 65535 : m_cnt[k] + 1;
            m_ovf[k] = m_ovf[k] | o;
          end
        end
      end
    end
    #1;
    chk("res_valid_a", rv_a, m_valid[0]);
    chk("res_valid_b", rv_b, m_valid[1]);
    if (m_valid[0]) begin
      chk("res_data_a", $signed(rd_a), m_data[0]);
      chk("res_terms_a", rt_a, m_terms[0]);
      chk("res_ovf_a", ro_a, m_rovf[0]);
      chk("res_data_b", $signed(rd_b), m_data[1]);
      chk("res_terms_b", rt_b, m_terms[1]);
      chk("res_ovf_b", ro_b, m_rovf[1]);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_valid[k] = 0;
      m_data[k] = 0; m_terms[k] = 0; m_rovf[k] = 0;
    end

    // Reset values.
    cyc(1, 0, 20'd0, 0, 0);
    chk("rst_valid", rv_a, 0);
    chk("rst_data", $signed(rd_a), 0);
    chk("rst_terms", rt_a, 0);
    chk("rst_ovf", ro_a, 0);
    chk("rst_data_b", $signed(rd_b), 0);
    cyc(0, 0, 20'd0, 0, 0);

    // 5, -3, 10 -> 12 over 3 terms, visible one cycle after the last accept.
    cyc(0, 1, 20'd5, 0, 0);
    cyc(0, 1, 20'hFFFFD, 0, 0);
    chk("dot_not_early", rv_a, 0);
    cyc(0, 1, 20'd10, 1, 0);
    chk("dot_data", $signed(rd_a), 12);
    chk("dot_terms", rt_a, 3);
    chk("dot_ovf", ro_a, 0);
    cyc(0, 0, 20'd0, 0, 1);
    chk("drain_clears", rv_a, 0);

    // Single term of -1.
    cyc(0, 1, 20'hFFFFF, 1, 0);
    chk("single_data", $signed(rd_a), -1);
    chk("single_terms", rt_a, 1);
    cyc(0, 0, 20'd0, 0, 1);

    // Result held with res_ready low while terms are offered.
    cyc(0, 1, 20'd9, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 20'd3, 0, 0);
      chk("hold_ready", rdy_a, 0);
      chk("hold_data", $signed(rd_a), 9);
    end
    cyc(0, 1, 20'd3, 1, 1);
    chk("release_data", $signed(rd_a), 3);
    chk("release_terms", rt_a, 1);
    cyc(0, 0, 20'd0, 0, 1);

    // Drain and new last-accept in the same cycle: no bubble.
    cyc(0, 1, 20'd9, 1, 0);
    chk("b2b_first", $signed(rd_a), 9);
    cyc(0, 1, 20'd4, 1, 1);
    chk("b2b_valid", rv_a, 1);
    chk("b2b_data", $signed(rd_a), 4);
    cyc(0, 0, 20'd0, 0, 1);

    // 458745 x3 into a 21-bit accumulator.
    cyc(0, 1, 20'd458745, 0, 0);
    cyc(0, 1, 20'd458745, 0, 0);
    cyc(0, 1, 20'd458745, 1, 0);
    chk("ovf32_data", $signed(rd_a), 1376235);
    chk("ovf32_flag", ro_a, 0);
`ifdef PSUM_ACC_SAT_EN
    chk("ovf21_data", $signed(rd_b), 1048575);
    chk("ovf21_flag", ro_b, 1);
`else
    chk("ovf21_data", $signed(rd_b), -720917);
    chk("ovf21_flag", ro_b, 0);
`endif
    chk("ovf21_terms", rt_b, 3);
    cyc(0, 0, 20'd0, 0, 1);

    // Partial row discarded by reset.
    cyc(0, 1, 20'd100, 0, 0);
    cyc(0, 1, 20'd200, 0, 0);
    cyc(1, 0, 20'd0, 0, 0);
    cyc(0, 1, 20'd7, 1, 0);
    chk("rst_row_data", $signed(rd_a), 7);
    chk("rst_row_terms", rt_a, 1);
    cyc(0, 0, 20'd0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [19:0] d;
      d = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 63)) - 20'd32
                                      : 20'($urandom);
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), d,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 20'd0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
